// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory stage: operation encodings, FSM states,
// default geometry and the stack-pointer reset derivation.
package mem_stage_pkg;

    localparam int unsigned DATA_W         = 16;
    localparam int unsigned OP_W           = 4;
    localparam int unsigned CCR_W          = 3;
    localparam int unsigned RD_W           = 3;
    localparam int unsigned ADDR_W_DEFAULT = 10;

    typedef enum logic [OP_W-1:0] {
        OP_NOP   = 4'd0,
        OP_LOAD  = 4'd1,
        OP_STORE = 4'd2,
        OP_PUSH  = 4'd3,
        OP_POP   = 4'd4,
        OP_CALL  = 4'd5,
        OP_RET   = 4'd6,
        OP_INT   = 4'd7,
        OP_RTI   = 4'd8
    } mem_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_INT2 = 2'd1,
        ST_RTI2 = 2'd2
    } state_e;

    // Stack starts at the top word of memory and grows downward.
    function automatic int unsigned sp_reset_for(input int unsigned addr_w);
        return (32'd1 << addr_w) - 32'd1;
    endfunction

endpackage

// File: rtl/mem_stage_data_memory.sv
// Single-port data memory, 2**ADDR_W x 16, synchronous write, combinational read.
// Ports: clk; we_i write enable; addr_i word address; wdata_i write data;
//        rdata_o combinational read data at addr_i.
module data_memory
    import mem_stage_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEFAULT
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/mem_stage.sv
// Memory stage: load/store, stack push/pop, CALL/RET and the two-access
// INT/RTI sequences; owns the stack pointer and registers the MEM/WB results.
// Ports: clk, rst (async, active-high); valid_i/mem_op_i/alu_out_i/addr_i/
//        store_data_i/pc_i/ccr_i/rd_i/reg_write_i from execute;
//        stall_o (combinational) back upstream; wb_* MEM/WB register;
//        pc_load_o/pc_value_o and ccr_load_o/ccr_value_o restore requests;
//        sp_o current stack pointer.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned ADDR_W   = ADDR_W_DEFAULT,
    parameter int unsigned SP_RESET = sp_reset_for(ADDR_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    input  logic [OP_W-1:0]   mem_op_i,
    input  logic [DATA_W-1:0] alu_out_i,
    input  logic [DATA_W-1:0] addr_i,
    input  logic [DATA_W-1:0] store_data_i,
    input  logic [DATA_W-1:0] pc_i,
    input  logic [CCR_W-1:0]  ccr_i,
    input  logic [RD_W-1:0]   rd_i,
    input  logic              reg_write_i,
    output logic              stall_o,
    output logic              wb_valid_o,
    output logic [DATA_W-1:0] wb_data_o,
    output logic [RD_W-1:0]   wb_rd_o,
    output logic              wb_reg_write_o,
    output logic              pc_load_o,
    output logic [DATA_W-1:0] pc_value_o,
    output logic              ccr_load_o,
    output logic [CCR_W-1:0]  ccr_value_o,
    output logic [ADDR_W-1:0] sp_o
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] sp_q, sp_d, sp_inc;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;

    logic              wb_valid_q, wb_valid_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;
    logic [RD_W-1:0]   wb_rd_q, wb_rd_d;
    logic              wb_rw_q, wb_rw_d;
    logic              pc_load_q, pc_load_d;
    logic [DATA_W-1:0] pc_value_q, pc_value_d;
    logic              ccr_load_q, ccr_load_d;
    logic [CCR_W-1:0]  ccr_value_q, ccr_value_d;

    // Only the low ADDR_W address bits select a word.
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr_i[DATA_W-1:ADDR_W];

    // Pops read the slot just above SP (empty-descending stack).
    assign sp_inc = sp_q + ADDR_W'(1);

    data_memory #(.ADDR_W(ADDR_W)) u_dmem (
        .clk     (clk),
        .we_i    (mem_we),
        .addr_i  (mem_addr),
        .wdata_i (mem_wdata),
        .rdata_o (mem_rdata)
    );

    // Decode: memory port steering, SP update, sequencing and next MEM/WB values.
    always_comb begin
        state_d     = state_q;
        sp_d        = sp_q;
        stall_o     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = addr_i[ADDR_W-1:0];
        mem_wdata   = store_data_i;
        wb_valid_d  = 1'b0;
        wb_data_d   = alu_out_i;
        wb_rd_d     = rd_i;
        wb_rw_d     = 1'b0;
        pc_load_d   = 1'b0;
        pc_value_d  = pc_value_q;
        ccr_load_d  = 1'b0;
        ccr_value_d = ccr_value_q;

        unique case (state_q)
            ST_IDLE: begin
                if (valid_i) begin
                    wb_valid_d = 1'b1;
                    wb_rw_d    = reg_write_i;
                    case (mem_op_i)
                        OP_LOAD: begin
                            wb_data_d = mem_rdata;
                        end
                        OP_STORE: begin
                            mem_we  = 1'b1;
                            wb_rw_d = 1'b0;
                        end
                        OP_PUSH: begin
                            mem_we   = 1'b1;
                            mem_addr = sp_q;
                            sp_d     = sp_q - ADDR_W'(1);
                            wb_rw_d  = 1'b0;
                        end
                        OP_POP: begin
                            mem_addr  = sp_inc;
                            sp_d      = sp_inc;
                            wb_data_d = mem_rdata;
                        end
                        OP_CALL: begin
                            mem_we    = 1'b1;
                            mem_addr  = sp_q;
                            mem_wdata = pc_i;
                            sp_d      = sp_q - ADDR_W'(1);
                            wb_rw_d   = 1'b0;
                        end
                        OP_RET: begin
                            mem_addr   = sp_inc;
                            sp_d       = sp_inc;
                            wb_rw_d    = 1'b0;
                            pc_load_d  = 1'b1;
                            pc_value_d = mem_rdata;
                        end
                        OP_INT: begin
                            // First half: push return PC; writeback waits for INT2.
                            mem_we     = 1'b1;
                            mem_addr   = sp_q;
                            mem_wdata  = pc_i;
                            sp_d       = sp_q - ADDR_W'(1);
                            state_d    = ST_INT2;
                            stall_o    = 1'b1;
                            wb_valid_d = 1'b0;
                            wb_rw_d    = 1'b0;
                        end
                        OP_RTI: begin
                            // First half: pop flags (pushed last by INT).
                            mem_addr    = sp_inc;
                            sp_d        = sp_inc;
                            state_d     = ST_RTI2;
                            stall_o     = 1'b1;
                            wb_valid_d  = 1'b0;
                            wb_rw_d     = 1'b0;
                            ccr_load_d  = 1'b1;
                            ccr_value_d = mem_rdata[CCR_W-1:0];
                        end
                        default: ;
                    endcase
                end
            end
            ST_INT2: begin
                // Inputs are held by upstream; finish without re-decoding.
                mem_we     = 1'b1;
                mem_addr   = sp_q;
                mem_wdata  = DATA_W'(ccr_i);
                sp_d       = sp_q - ADDR_W'(1);
                state_d    = ST_IDLE;
                wb_valid_d = 1'b1;
            end
            ST_RTI2: begin
                mem_addr   = sp_inc;
                sp_d       = sp_inc;
                state_d    = ST_IDLE;
                wb_valid_d = 1'b1;
                pc_load_d  = 1'b1;
                pc_value_d = mem_rdata;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM, stack pointer and MEM/WB boundary registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            sp_q        <= ADDR_W'(SP_RESET);
            wb_valid_q  <= 1'b0;
            wb_data_q   <= '0;
            wb_rd_q     <= '0;
            wb_rw_q     <= 1'b0;
            pc_load_q   <= 1'b0;
            pc_value_q  <= '0;
            ccr_load_q  <= 1'b0;
            ccr_value_q <= '0;
        end else begin
            state_q     <= state_d;
            sp_q        <= sp_d;
            wb_valid_q  <= wb_valid_d;
            wb_data_q   <= wb_data_d;
            wb_rd_q     <= wb_rd_d;
            wb_rw_q     <= wb_rw_d;
            pc_load_q   <= pc_load_d;
            pc_value_q  <= pc_value_d;
            ccr_load_q  <= ccr_load_d;
            ccr_value_q <= ccr_value_d;
        end
    end

    assign wb_valid_o     = wb_valid_q;
    assign wb_data_o      = wb_data_q;
    assign wb_rd_o        = wb_rd_q;
    assign wb_reg_write_o = wb_rw_q;
    assign pc_load_o      = pc_load_q;
    assign pc_value_o     = pc_value_q;
    assign ccr_load_o     = ccr_load_q;
    assign ccr_value_o    = ccr_value_q;
    assign sp_o           = sp_q;

endmodule
